if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage: owns the PC, issues word requests to instruction memory over a
//  req/ack handshake, and presents {pc_o, instr_o, MemStall_o} to the IF/ID pipeline register.
//  Absorbs memory latency, holds a fetched word while decode stalls, and squashes fetches
//  that are in flight when a branch/jump redirect arrives.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC loaded on reset; bits [1:0] must be 0
// PORTS
//  clk_i             in   1   clock; all state updates on posedge
//  rst_n_i           in   1   asynchronous, active-low reset
//  stall_i           in   1   hazard stall from decode; IF/ID will not capture this cycle
//  redirect_i        in   1   taken branch/jump resolved this cycle
//  redirect_pc_i     in   32  redirect target; bits [1:0] ignored (forced 0)
//  imem_req_o        out  1   fetch request; held high with stable addr until ack
//  imem_addr_o       out  32  fetch address (word aligned)
//  imem_ack_i        in   1   one-cycle pulse; imem_rdata_i valid in same cycle
//  imem_rdata_i      in   32  fetched instruction word
//  pc_o              out  32  PC of instruction on instr_o
//  instr_o           out  32  instruction presented to IF/ID
//  MemStall_o        out  1   1 = no valid instruction this cycle; IF/ID must hold
// BEHAVIOUR
//  - Reset (rst_n_i=0, async): state=IDLE, pc_q=RESET_PC, pend_q=0, buf_q=0. Outputs:
//    imem_req_o=0, imem_addr_o=RESET_PC, pc_o=RESET_PC, instr_o=0, MemStall_o=1.
//    Reset mid-request abandons the transaction; any later ack is ignored in IDLE.
//  - States: IDLE, FETCH, HOLD, DROP. IDLE lasts exactly one cycle after reset release -> FETCH.
//  - FETCH: imem_req_o=1, imem_addr_o=pc_q, pc_o=pc_q, instr_o=imem_rdata_i (comb. bypass).
//    MemStall_o = ~imem_ack_i | redirect_i. Priority on each edge:
//      redirect_i & ack   : pc_q<=target, stay FETCH (word discarded)
//      redirect_i & ~ack  : pend_q<=target, ->DROP (req must stay up until ack)
//      ack & stall_i      : buf_q<=imem_rdata_i, ->HOLD (pc_q unchanged)
//      ack & ~stall_i     : pc_q<=pc_q+4, stay FETCH (next req issued next cycle)
//      no ack             : stay FETCH, no change
//    Zero-wait memory (ack same cycle as req) sustains one instruction per cycle.
//  - HOLD: imem_req_o=0, instr_o=buf_q, pc_o=pc_q, MemStall_o=redirect_i.
//      redirect_i: pc_q<=target ->FETCH; else ~stall_i: pc_q<=pc_q+4 ->FETCH; else stay.
//  - DROP: imem_req_o=1, imem_addr_o=pc_q (original), MemStall_o=1, instr_o=imem_rdata_i.
//      redirect_i again: pend_q<=new target (latest wins). On ack: pc_q<=pend_q
//      (or new target if redirect_i same cycle) ->FETCH; returned word never delivered.
//  - Redirect has priority over stall_i everywhere. Caller flushes IF/ID on redirect.
//  - PC arithmetic: 32-bit, pc_q+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.
//  - imem_ack_i while imem_req_o=0 (IDLE/HOLD) is ignored; no state change.
//  - imem_addr_o/pc_o never change while imem_req_o=1 and ack not yet seen.
//  - instr_o/pc_o are don't-care whenever MemStall_o=1; bench checks them only when 0.
// STRUCTURE
//  - fetch_defs.vh: state encodings (IDLE=2'd0, FETCH=2'd1, HOLD=2'd2, DROP=2'd3),
//    RESET_PC default, NOP word 32'h0000_0013 for bench use.
//  - Single module; no sub-module. Registers: state_q, pc_q, pend_q, buf_q.
//    next-state/next-pc in one combinational block, flops in one async-reset block.
// TESTING
//  1 Reset, zero-wait mem (ack=req): addr sequence 0,4,8,12 on consecutive cycles after
//    IDLE; MemStall_o=0 every cycle from first FETCH; pc_o matches addr.
//  2 Mem latency 3 cycles: req held, addr stable 3 cycles, MemStall_o=1,1,0; pc_o=0,
//    instr_o=rdata on ack cycle; next req addr=4.
//  3 stall_i=1 for 4 cycles at ack of pc=8: ->HOLD, req=0, instr_o=buffered word,
//    MemStall_o=0 throughout; stall release -> next req addr=12.
//  4 redirect_i (target 32'h100) 1 cycle after req for pc=16, ack 2 cycles later:
//    addr stays 16 until ack, MemStall_o=1, word dropped; next req addr=32'h100.
//  5 Two redirects in DROP (0x200 then 0x300): next fetch addr=0x300; redirect in HOLD
//    with stall_i=1: next addr=target, stall ignored.
//  6 RESET_PC=32'hFFFF_FFF8: fetches FFF8, FFFC, 0000; rst_n_i low mid-latency:
//    req drops immediately, late ack ignored, restart at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states and fixed constants.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0013;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem req/ack handshake and
// presents {pc_o, instr_o, MemStall_o} to IF/ID, holding or squashing words as needed.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        MemStall_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_q, pend_d;
  logic [31:0]  buf_q, buf_d;
  logic [31:0]  tgt;
  logic [31:0]  pc_inc;

  assign tgt    = redirect_pc_i & ~32'd3;
  assign pc_inc = pc_q + 32'd4;

  // pc_q only moves on ack or from HOLD, so address stays stable while a request is open
  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    buf_d      = buf_q;
    imem_req_o = 1'b0;
    instr_o    = '0;
    MemStall_o = 1'b1;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end

      FETCH: begin
        imem_req_o = 1'b1;
        instr_o    = imem_rdata_i;
        MemStall_o = ~imem_ack_i | redirect_i;
        if (redirect_i && imem_ack_i) begin
          pc_d = tgt;
        end else if (redirect_i) begin
          pend_d  = tgt;
          state_d = DROP;
        end else if (imem_ack_i && stall_i) begin
          buf_d   = imem_rdata_i;
          state_d = HOLD;
        end else if (imem_ack_i) begin
          pc_d = pc_inc;
        end
      end

      HOLD: begin
        instr_o    = buf_q;
        MemStall_o = redirect_i;
        if (redirect_i) begin
          pc_d    = tgt;
          state_d = FETCH;
        end else if (!stall_i) begin
          pc_d    = pc_inc;
          state_d = FETCH;
        end
      end

      DROP: begin
        // Request must complete before the redirect target can be issued
        imem_req_o = 1'b1;
        instr_o    = imem_rdata_i;
        if (imem_ack_i) begin
          pc_d    = redirect_i ? tgt : pend_q;
          state_d = FETCH;
        end else if (redirect_i) begin
          pend_d = tgt;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus randomized traffic checked against
// an in-order instruction-stream scoreboard and a latency-programmable memory model.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_n_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        MemStall_o;

  logic        rst2_n = 1'b0;
  logic        stall2 = 1'b0;
  logic        redir2 = 1'b0;
  logic [31:0] redir2_pc = '0;
  logic        req2;
  logic [31:0] addr2;
  logic        ack2 = 1'b0;
  logic [31:0] rdata2 = '0;
  logic [31:0] pc2;
  logic [31:0] instr2;
  logic        ms2;

  if_fetch_unit dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i), .pc_o(pc_o),
    .instr_o(instr_o), .MemStall_o(MemStall_o)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_hi (
    .clk_i(clk_i), .rst_n_i(rst2_n), .stall_i(stall2), .redirect_i(redir2),
    .redirect_pc_i(redir2_pc), .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_ack_i(ack2), .imem_rdata_i(rdata2), .pc_o(pc2),
    .instr_o(instr2), .MemStall_o(ms2)
  );

  int ntests = 0;
  int nfail  = 0;

  int          cfg_lat = 0;
  bit          spur_mode = 1'b0;
  bit          spur_ack = 1'b0;
  bit          req_open = 1'b0;
  int          wcnt = 0;
  int          cur_lat = 0;
  bit          stab_pending = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] exp_pc = RESET_PC_DEFAULT;
  bit          progress = 1'b0;
  int          delivered = 0;

  logic        obs_req;
  logic [31:0] obs_addr;
  logic        obs_ms;
  logic [31:0] obs_pc;
  logic [31:0] obs_instr;

  // Program image: every address holds a distinct, recognisable word
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ NOP_WORD;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input bit st, input bit rd, input logic [31:0] rpc);
    @(negedge clk_i);
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    if (stab_pending) begin
      chk("req_held", {31'd0, imem_req_o}, 32'd1);
      chk("addr_stable", imem_addr_o, prev_addr);
    end
    if (imem_req_o) begin
      if (!req_open) begin
        req_open = 1'b1;
        wcnt     = 0;
        cur_lat  = (cfg_lat < 0) ? int'($urandom_range(0, 3)) : cfg_lat;
      end
      imem_ack_i   = (wcnt >= cur_lat);
      wcnt++;
      imem_rdata_i = imem_ack_i ? mem_word(imem_addr_o) : $urandom;
    end else begin
      imem_ack_i   = spur_mode ? ($urandom_range(0, 3) == 0) : spur_ack;
      imem_rdata_i = $urandom;
    end
    #1;
    obs_req   = imem_req_o;
    obs_addr  = imem_addr_o;
    obs_ms    = MemStall_o;
    obs_pc    = pc_o;
    obs_instr = instr_o;
    progress  = 1'b0;
    if (!MemStall_o) begin
      chk("sb_pc", pc_o, exp_pc);
      chk("sb_instr", instr_o, mem_word(exp_pc));
    end
    if (rd) begin
      exp_pc   = {rpc[31:2], 2'b00};
      progress = 1'b1;
    end else if (!MemStall_o && !st) begin
      exp_pc   = exp_pc + 32'd4;
      progress = 1'b1;
      delivered++;
    end
    if (imem_req_o && imem_ack_i) req_open = 1'b0;
    stab_pending = imem_req_o && !imem_ack_i;
    prev_addr    = imem_addr_o;
  endtask

  task automatic do_reset(input bit late_ack);
    rst_n_i      = 1'b0;
    stall_i      = 1'b0;
    redirect_i   = 1'b0;
    imem_ack_i   = late_ack;
    imem_rdata_i = $urandom;
    #1;
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_addr", imem_addr_o, RESET_PC_DEFAULT);
    chk("rst_pc", pc_o, RESET_PC_DEFAULT);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_stall", {31'd0, MemStall_o}, 32'd1);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    chk("idle_req", {31'd0, imem_req_o}, 32'd0);
    chk("idle_stall", {31'd0, MemStall_o}, 32'd1);
    req_open     = 1'b0;
    stab_pending = 1'b0;
    exp_pc       = RESET_PC_DEFAULT;
  endtask

  initial begin
    logic [31:0] e2;
    logic [1:0]  ms_seq;
    int          since;
    int          max_since;

    // Zero-wait memory streams one instruction per cycle
    do_reset(1'b0);
    cfg_lat = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, '0);
      chk("t1_addr", obs_addr, 32'(i * 4));
      chk("t1_stall", {31'd0, obs_ms}, 32'd0);
    end

    // Three-cycle memory latency
    do_reset(1'b0);
    cfg_lat = 2;
    ms_seq  = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0);
      chk("t2_addr", obs_addr, 32'd0);
      chk("t2_stall", {31'd0, obs_ms}, (i < 2) ? {31'd0, ms_seq[i]} : 32'd0);
    end
    chk("t2_pc", obs_pc, 32'd0);
    chk("t2_instr", obs_instr, mem_word(32'd0));
    cfg_lat = 0;
    step(1'b0, 1'b0, '0);
    chk("t2_next", obs_addr, 32'd4);

    // Decode stall at the ack of pc=8 parks the word in HOLD
    step(1'b1, 1'b0, '0);
    chk("t3_addr", obs_addr, 32'd8);
    chk("t3_stall0", {31'd0, obs_ms}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, '0);
      chk("t3_req", {31'd0, obs_req}, 32'd0);
      chk("t3_stall", {31'd0, obs_ms}, 32'd0);
      chk("t3_instr", obs_instr, mem_word(32'd8));
    end
    step(1'b0, 1'b0, '0);
    chk("t3_rel_req", {31'd0, obs_req}, 32'd0);
    step(1'b0, 1'b0, '0);
    chk("t3_next", obs_addr, 32'd12);
    chk("t3_next_req", {31'd0, obs_req}, 32'd1);

    // Redirect while a request is outstanding
    cfg_lat = 3;
    step(1'b0, 1'b0, '0);
    chk("t4_addr0", obs_addr, 32'd16);
    step(1'b0, 1'b1, 32'h100);
    chk("t4_addr1", obs_addr, 32'd16);
    chk("t4_stall1", {31'd0, obs_ms}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, '0);
      chk("t4_addr", obs_addr, 32'd16);
      chk("t4_stall", {31'd0, obs_ms}, 32'd1);
    end
    cfg_lat = 0;
    step(1'b0, 1'b0, '0);
    chk("t4_target", obs_addr, 32'h100);

    // Latest redirect wins in DROP; redirect beats stall in HOLD
    cfg_lat = 3;
    step(1'b0, 1'b0, '0);
    chk("t5_addr", obs_addr, 32'h104);
    step(1'b0, 1'b1, 32'h200);
    step(1'b0, 1'b1, 32'h303);
    step(1'b0, 1'b0, '0);
    chk("t5_drop_addr", obs_addr, 32'h104);
    cfg_lat = 0;
    step(1'b0, 1'b0, '0);
    chk("t5_target", obs_addr, 32'h300);
    chk("t5_tstall", {31'd0, obs_ms}, 32'd0);
    step(1'b1, 1'b0, '0);
    chk("t5_hold_addr", obs_addr, 32'h304);
    step(1'b1, 1'b1, 32'h400);
    chk("t5_hold_redir", {31'd0, obs_ms}, 32'd1);
    step(1'b1, 1'b0, '0);
    chk("t5_after_hold", obs_addr, 32'h400);
    chk("t5_after_req", {31'd0, obs_req}, 32'd1);

    // Reset in the middle of a slow fetch; late ack must be ignored
    cfg_lat = 3;
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    chk("t6_pending", {31'd0, obs_req}, 32'd1);
    do_reset(1'b1);
    spur_ack = 1'b0;
    cfg_lat  = 0;
    step(1'b0, 1'b0, '0);
    chk("t6_restart", obs_addr, RESET_PC_DEFAULT);
    chk("t6_rstall", {31'd0, obs_ms}, 32'd0);

    // Non-zero RESET_PC with address wrap
    @(negedge clk_i);
    rst2_n = 1'b1;
    #1;
    chk("t6_hi_idle", {31'd0, req2}, 32'd0);
    e2 = 32'hFFFF_FFF8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      ack2   = req2;
      rdata2 = mem_word(addr2);
      #1;
      chk("t6_hi_addr", addr2, e2);
      chk("t6_hi_pc", pc2, e2);
      chk("t6_hi_stall", {31'd0, ms2}, 32'd0);
      e2 = e2 + 32'd4;
    end
    @(negedge clk_i);
    ack2 = 1'b0;

    // Randomized traffic against the instruction-stream scoreboard
    do_reset(1'b0);
    cfg_lat   = -1;
    spur_mode = 1'b1;
    since     = 0;
    max_since = 0;
    delivered = 0;
    for (int i = 0; i < 2000; i++) begin
      bit          st;
      bit          rd;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : 32'($urandom);
      step(st, rd, rpc);
      if (progress) since = 0;
      else if (!st) since++;
      if (since > max_since) max_since = since;
      if (max_since > 40) break;
    end
    spur_mode = 1'b0;
    chk("rand_liveness", {31'd0, max_since <= 40}, 32'd1);
    chk("rand_throughput", {31'd0, delivered > 200}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
